// File: rtl/pattern_matcher_lockout.sv
// Serial LSB-first secret matcher: always consumes the full pattern before reporting,
// counts consecutive failures and enters a timed lockout after MAX_FAILS of them.
module pattern_matcher_lockout #(
  parameter int                       PATTERN_BITS   = 16,
  parameter logic [PATTERN_BITS-1:0]  PATTERN        = 16'h1982,
  parameter int                       BYTE_BITS      = 8,
  parameter int                       MAX_FAILS      = 3,
  parameter int                       LOCKOUT_CYCLES = 1000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rx_bit,
  input  logic                             rx_bit_valid_now,
  input  logic                             rx_byte_start,
  output logic                             tx_which_byte,
  output logic                             tx_trigger,
  input  logic                             tx_done,
  output logic                             locked,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);

  localparam int CW = $clog2(PATTERN_BITS + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int FW = $clog2(MAX_FAILS + 1);

  typedef enum logic [1:0] {MATCH, REPORT, WAIT_TX, LOCKOUT} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  bit_cnt;
  logic [LW-1:0]  lock_cnt;
  logic [FW-1:0]  fail_q;
  logic           match_q;
  logic           expected_bit;
  logic           legal_start;
  logic           desync;
  logic           last_bit;
  logic           lock_done;
  logic           fail_sat;

  // Mux instead of a direct variable select keeps the index width exact for any length.
  always_comb begin
    expected_bit = 1'b0;
    for (int i = 0; i < PATTERN_BITS; i++) begin
      if (bit_cnt == CW'(i)) expected_bit = PATTERN[i];
    end
  end

  assign legal_start = ((32'(bit_cnt) % BYTE_BITS) == 0);
  assign desync      = rx_byte_start && !legal_start;
  assign last_bit    = (bit_cnt == CW'(PATTERN_BITS - 1));
  assign lock_done   = (lock_cnt == '0);
  assign fail_sat    = (fail_q == FW'(MAX_FAILS));

  always_ff @(posedge clk) begin
    if (rst) state <= MATCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MATCH:   if (rx_bit_valid_now && !desync && last_bit) state_next = REPORT;
      REPORT:  state_next = WAIT_TX;
      WAIT_TX: if (tx_done) state_next = fail_sat ? LOCKOUT : MATCH;
      LOCKOUT: if (lock_done) state_next = MATCH;
      default: state_next = MATCH;
    endcase
  end

  // A resync restarts the bit position but never clears an earlier mismatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      lock_cnt <= '0;
      fail_q   <= '0;
      match_q  <= 1'b1;
    end else begin
      case (state)
        MATCH: begin
          if (rx_bit_valid_now) begin
            if (desync) begin
              if (rx_bit != PATTERN[0]) match_q <= 1'b0;
              bit_cnt <= CW'(1);
            end else begin
              if (rx_bit != expected_bit) match_q <= 1'b0;
              if (!last_bit) bit_cnt <= bit_cnt + CW'(1);
            end
          end
        end
        REPORT: begin
          if (match_q)       fail_q <= '0;
          else if (!fail_sat) fail_q <= fail_q + FW'(1);
        end
        WAIT_TX: begin
          if (tx_done) begin
            bit_cnt <= '0;
            if (fail_sat) lock_cnt <= LW'(LOCKOUT_CYCLES - 1);
            else          match_q  <= 1'b1;
          end
        end
        LOCKOUT: begin
          if (lock_done) begin
            fail_q  <= FW'(MAX_FAILS - 1);
            match_q <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt - LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_trigger    = (state == REPORT);
    locked        = (state == LOCKOUT);
    tx_which_byte = match_q && (state != LOCKOUT);
    fail_count    = fail_q;
  end

endmodule

// File: tb/tb_pattern_matcher_lockout.sv
// Self-checking bench: table vectors, hand-written corner sequences and randomized
// attempts scored against a position-counting reference model.
module tb_pattern_matcher_lockout;

  localparam int MAXF = 3;
  localparam int LOCK = 10;
  localparam int BYTE = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_bit = 1'b0;
  logic rx_bit_valid_now = 1'b0;
  logic rx_byte_start = 1'b0;
  logic tx_done = 1'b0;

  logic which16, trig16, lock16, which64, trig64, lock64;
  logic [1:0] fc16, fc64;
  logic sel = 1'b0;

  logic which, trig, lck;
  logic [1:0] fc;

  int checks = 0;
  int failures = 0;

  typedef struct packed {logic b; logic s;} rx_t;
  rx_t stream[$];
  logic [63:0] cur_pat = 64'h1982;
  int cur_pb = 16;
  int model_fc = 0;

  typedef struct {
    logic [15:0] word;
    logic [15:0] starts;
    bit          done_rep;
    bit          exp_pass;
    int          exp_fc;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  pattern_matcher_lockout #(
    .PATTERN_BITS(16), .PATTERN(16'h1982), .BYTE_BITS(BYTE),
    .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LOCK)
  ) dut16 (
    .clk(clk), .rst(rst), .rx_bit(rx_bit), .rx_bit_valid_now(rx_bit_valid_now),
    .rx_byte_start(rx_byte_start), .tx_which_byte(which16), .tx_trigger(trig16),
    .tx_done(tx_done), .locked(lock16), .fail_count(fc16)
  );

  pattern_matcher_lockout #(
    .PATTERN_BITS(64), .PATTERN(64'hF836_98CB_BAF8_1644), .BYTE_BITS(BYTE),
    .MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LOCK)
  ) dut64 (
    .clk(clk), .rst(rst), .rx_bit(rx_bit), .rx_bit_valid_now(rx_bit_valid_now),
    .rx_byte_start(rx_byte_start), .tx_which_byte(which64), .tx_trigger(trig64),
    .tx_done(tx_done), .locked(lock64), .fail_count(fc64)
  );

  assign which = sel ? which64 : which16;
  assign trig  = sel ? trig64  : trig16;
  assign lck   = sel ? lock64  : lock16;
  assign fc    = sel ? fc64    : fc16;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic b, input logic s, input logic d);
    rx_bit_valid_now = v;
    rx_bit           = b;
    rx_byte_start    = s;
    tx_done          = d;
    @(posedge clk);
    #1;
    rx_bit_valid_now = 1'b0;
    rx_byte_start    = 1'b0;
    tx_done          = 1'b0;
  endtask

  task automatic idle_noise();
    applyStimulus(1'b0, 1'($urandom % 2), 1'($urandom % 2), 1'b0);
  endtask

  task automatic check_reset(input string name);
    checkOutput({name, "_which"}, 64'(which), 64'd1);
    checkOutput({name, "_trig"},  64'(trig),  64'd0);
    checkOutput({name, "_lock"},  64'(lck),   64'd0);
    checkOutput({name, "_fc"},    64'(fc),    64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic build_word(input logic [63:0] w, input logic [63:0] st, input int n);
    stream.delete();
    for (int i = 0; i < n; i++) stream.push_back({w[i], st[i]});
  endtask

  // Reference: walk the attempt as a pattern position; a byte-start off a byte
  // boundary restarts at position 1, the attempt completes when every position is seen.
  function automatic void model_attempt(output int rep_idx, output bit pass, output int pos);
    pos = 0; pass = 1'b1; rep_idx = -1;
    for (int i = 0; i < stream.size(); i++) begin
      if (stream[i].s && (pos % BYTE) != 0) begin
        if (stream[i].b != cur_pat[0]) pass = 1'b0;
        pos = 1;
      end else begin
        if (stream[i].b != cur_pat[pos]) pass = 1'b0;
        pos++;
        if (pos == cur_pb) begin
          rep_idx = i;
          break;
        end
      end
    end
  endfunction

  task automatic gen_random_attempt();
    int r, pos;
    bit p;
    logic s, e;
    stream.delete();
    while (stream.size() < 400) begin
      model_attempt(r, p, pos);
      if (r >= 0) break;
      if (pos % BYTE == 0) s = 1'($urandom % 2);
      else                 s = ($urandom % 12) == 0;
      e = (s && (pos % BYTE) != 0) ? cur_pat[0] : cur_pat[pos];
      stream.push_back({e ^ (($urandom % 24) == 0), s});
    end
  endtask

  task automatic run_stream(input string name, input bit exp_pass, input int exp_fc,
                            input int gapmax, input bit done_rep);
    bit early = 1'b0;
    int last = stream.size() - 1;
    for (int i = 0; i <= last; i++) begin
      if (i > 0 && gapmax > 0) repeat ($urandom_range(gapmax, 0)) idle_noise();
      applyStimulus(1'b1, stream[i].b, stream[i].s, 1'b0);
      if (i < last && trig) early = 1'b1;
    end
    checkOutput({name, "_no_early_trig"}, 64'(early), 64'd0);
    checkOutput({name, "_trig"}, 64'(trig), 64'd1);
    checkOutput({name, "_which"}, 64'(which), 64'(exp_pass));
    applyStimulus(1'b0, 1'b0, 1'b0, done_rep);
    checkOutput({name, "_trig_pulse"}, 64'(trig), 64'd0);
    checkOutput({name, "_fc"}, 64'(fc), 64'(exp_fc));
  endtask

  task automatic finish_tx(input string name, input bit exp_pass, input bit exp_lock);
    repeat ($urandom_range(3, 0))
      applyStimulus(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2), 1'b0);
    checkOutput({name, "_hold"}, 64'(which), 64'(exp_pass));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput({name, "_lock"}, 64'(lck), 64'(exp_lock));
    checkOutput({name, "_which_after"}, 64'(which), 64'(!exp_lock));
  endtask

  task automatic wait_lockout(input string name, input int exp_len, input int exp_fc);
    int n = 1;
    bit bad = 1'b0;
    while (lck && n <= 200) begin
      if (which !== 1'b0 || fc !== 2'(MAXF)) bad = 1'b1;
      applyStimulus(1'b1, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
      if (lck) n++;
    end
    checkOutput({name, "_len"}, 64'(n), 64'(exp_len));
    checkOutput({name, "_outputs_during"}, 64'(bad), 64'd0);
    checkOutput({name, "_fc_after"}, 64'(fc), 64'(exp_fc));
    checkOutput({name, "_which_after"}, 64'(which), 64'd1);
  endtask

  task automatic fail_attempt(input string name, input int exp_fc, input bit exp_lock);
    build_word(64'h0000, 64'h0101, 16);
    run_stream(name, 1'b0, exp_fc, 1, 1'b0);
    finish_tx(name, 1'b0, exp_lock);
  endtask

  task automatic pass_attempt(input string name);
    build_word(64'h1982, 64'h0101, 16);
    run_stream(name, 1'b1, 0, 1, 1'b0);
    finish_tx(name, 1'b1, 1'b0);
  endtask

  initial begin
    int r, pos;
    bit p;
    vecs[0] = '{16'h1982, 16'h0101, 1'b0, 1'b1, 0};
    vecs[1] = '{16'h1983, 16'h0101, 1'b1, 1'b0, 1};
    vecs[2] = '{16'h9982, 16'h0001, 1'b0, 1'b0, 2};
    vecs[3] = '{16'h1982, 16'h0000, 1'b0, 1'b1, 0};
    vecs[4] = '{16'h0000, 16'h0101, 1'b1, 1'b0, 1};
    vecs[5] = '{16'h1982, 16'h0101, 1'b0, 1'b1, 0};
    vecs[6] = '{16'hE67D, 16'h0000, 1'b0, 1'b0, 1};
    vecs[7] = '{16'h1982, 16'h0101, 1'b0, 1'b1, 0};

    do_reset();
    check_reset("reset");

    for (int i = 0; i < 8; i++) begin
      build_word(64'(vecs[i].word), 64'(vecs[i].starts), 16);
      run_stream($sformatf("vec%0d", i), vecs[i].exp_pass, vecs[i].exp_fc, 1, vecs[i].done_rep);
      finish_tx($sformatf("vec%0d", i), vecs[i].exp_pass, 1'b0);
    end

    for (int k = 0; k < 2; k++) begin
      stream.delete();
      for (int i = 0; i < 5; i++) stream.push_back({cur_pat[i] ^ (k == 1 && i == 2), i == 0});
      stream.push_back({cur_pat[0], 1'b1});
      for (int j = 1; j < 16; j++) stream.push_back({cur_pat[j], j == 8});
      run_stream($sformatf("desync%0d", k), k == 0, k, 1, 1'b0);
      finish_tx($sformatf("desync%0d", k), k == 0, 1'b0);
    end

    for (int i = 0; i < 9; i++) applyStimulus(1'b1, cur_pat[i] ^ (i == 0), i == 0 || i == 8, 1'b0);
    checkOutput("mid_attempt_sticky", 64'(which), 64'd0);
    rst = 1'b1;
    applyStimulus(1'b1, cur_pat[9], 1'b0, 1'b1);
    rst = 1'b0;
    check_reset("rst_mid_attempt");
    pass_attempt("after_rst_mid");

    build_word(64'h0000, 64'h0101, 16);
    run_stream("wait_tx_fail", 1'b0, 1, 1, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    check_reset("rst_wait_tx");
    pass_attempt("after_rst_wait");

    do_reset();
    fail_attempt("lk_f1", 1, 1'b0);
    fail_attempt("lk_f2", 2, 1'b0);
    fail_attempt("lk_f3", 3, 1'b1);
    wait_lockout("lockout1", LOCK, MAXF - 1);
    fail_attempt("lk_f4", 3, 1'b1);
    wait_lockout("lockout2", LOCK, MAXF - 1);
    pass_attempt("lk_clear");

    fail_attempt("lr_f1", 1, 1'b0);
    fail_attempt("lr_f2", 2, 1'b0);
    fail_attempt("lr_f3", 3, 1'b1);
    repeat (3) idle_noise();
    checkOutput("lockout_cycle4", 64'(lck), 64'd1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    check_reset("rst_lockout");
    pass_attempt("after_rst_lockout");

    do_reset();
    model_fc = 0;
    for (int k = 0; k < 30; k++) begin
      gen_random_attempt();
      model_attempt(r, p, pos);
      if (r < 0) continue;
      model_fc = p ? 0 : (model_fc < MAXF ? model_fc + 1 : MAXF);
      run_stream($sformatf("rand%0d", k), p, model_fc, 2, 1'($urandom % 2));
      finish_tx($sformatf("rand%0d", k), p, model_fc == MAXF);
      if (model_fc == MAXF) begin
        wait_lockout($sformatf("rand%0d_lock", k), LOCK, MAXF - 1);
        model_fc = MAXF - 1;
      end
    end

    sel = 1'b1;
    cur_pat = 64'hF836_98CB_BAF8_1644;
    cur_pb = 64;
    do_reset();
    check_reset("rst64");
    build_word(cur_pat, 64'h0101_0101_0101_0101, 64);
    run_stream("p64_pass", 1'b1, 0, 1, 1'b0);
    finish_tx("p64_pass", 1'b1, 1'b0);
    build_word(cur_pat ^ (64'h1 << 63), 64'h0101_0101_0101_0101, 64);
    run_stream("p64_bit63", 1'b0, 1, 1, 1'b0);
    finish_tx("p64_bit63", 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
